echo_timer: RTL and testbench
=============================

// Module: echo_timer
// PURPOSE
//  Parametrised ultrasonic echo pulse-width timer for the theremin sensor path.
//  Armed by the trigger generator, it waits for the echo pulse and measures its high time in
//  prescaled ticks (default 1 us). It reports a latched width with a valid strobe, or a timeout
//  when no echo arrives or the echo is too long. Adds synchronisation, arming, timeout and
//  saturation to the plain echo counter.
// PARAMETERS
//  WIDTH        16     width of width_out and the internal tick counters
//  CLK_DIV      50     clk_in cycles per tick (50 MHz -> 1 us); >= 2
//  TIMEOUT      30000  max ticks for both the rise wait and the pulse width; <= 2**WIDTH-1
//  SYNC_STAGES  2      flip-flop stages synchronising echo_in; >= 2
// PORTS
//  clk_in       in   1      system clock
//  reset        in   1      asynchronous, active-high reset
//  arm_in       in   1      1-cycle pulse: open a measurement window (from trigger block)
//  echo_in      in   1      raw asynchronous echo from the sensor
//  width_out    out  WIDTH  last valid pulse width in ticks; held until next valid
//  valid_out    out  1      1-cycle strobe: width_out updated this cycle
//  timeout_out  out  1      1-cycle strobe: window ended without a valid measurement
//  busy_out     out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (async, any time, incl. mid-measurement): state=IDLE; all outputs, counters,
//   prescaler and sync chain cleared to 0. Operation resumes on the first clock after release.
//  Sync: echo_s = last of SYNC_STAGES flops; echo_d = echo_s delayed 1 cycle.
//   rise = echo_s & ~echo_d; fall = ~echo_s & echo_d.
//  Prescaler: counts 0..CLK_DIV-1 in WAIT_RISE/MEASURE; tick when prescaler==CLK_DIV-1.
//   Cleared on every state entry.
//  FSM (all outputs registered):
//   IDLE:      busy=0. arm_in -> WAIT_RISE (elapsed=0). echo level ignored.
//   WAIT_RISE: elapsed++ on tick.
//              rise -> MEASURE (count=0).
//              else elapsed==TIMEOUT -> timeout_out=1, IDLE.
//              An echo already high at arm does not produce rise; it is not measured.
//   MEASURE:   count++ on tick.
//              fall -> width_out=count (incl. a tick in the same cycle), valid_out=1, IDLE.
//              else count==TIMEOUT -> timeout_out=1, WAIT_LOW; width_out unchanged.
//              Fall and saturation in the same cycle: fall wins; width_out=TIMEOUT.
//   WAIT_LOW:  echo_s==0 -> IDLE. Prevents the tail of a long echo being re-measured.
//  arm_in outside IDLE is ignored; no queueing.
//  valid_out and timeout_out are mutually exclusive and never high two cycles in a row.
//  Latency: valid_out rises at the SYNC_STAGES-th clk_in edge after the edge that first
//   samples echo_in low.
//  Width rule: whole ticks only, truncating. With H = high clocks,
//   width_out = floor(H/CLK_DIV) +/- 1 (sync jitter); width_out never exceeds TIMEOUT.
//  Counters never wrap: each stops at TIMEOUT by the transition rules above.
// TESTING (bench uses WIDTH=8, CLK_DIV=4, TIMEOUT=20, SYNC_STAGES=2; echo edges clock-aligned)
//  1 arm, echo high 10 clk later for exactly 40 clk -> one valid_out pulse, width_out=10,
//    busy drops with valid, timeout_out never asserted.
//  2 arm, echo high 43 clk -> width_out=10 (truncation); repeat with 44 clk -> width_out=11.
//  3 arm, no echo -> timeout_out single pulse ~80 clk after arm, width_out keeps prior value,
//    busy_out=0 next cycle.
//  4 arm, echo high 120 clk -> timeout_out at saturation, no valid_out, busy_out high until
//    echo low + 2 clk, then IDLE.
//  5 echo high before arm and kept high 30 clk after arm, then low, then 16 clk high pulse ->
//    first pulse ignored, width_out=4.
//  6 reset asserted mid-MEASURE (asynchronously, between edges) -> all outputs 0 immediately;
//    after release, arm + 40 clk echo -> width_out=10; arm_in pulses while busy change nothing.

Source files
------------

// File: rtl/echo_timer.sv
// Ultrasonic echo pulse-width timer: arms on a trigger pulse, waits for the echo
// rising edge, measures its high time in prescaled ticks and reports either a
// latched width with a valid strobe or a timeout strobe.
module echo_timer #(
  parameter int WIDTH       = 16,
  parameter int CLK_DIV     = 50,
  parameter int TIMEOUT     = 30000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             arm_in,
  input  logic             echo_in,
  output logic [WIDTH-1:0] width_out,
  output logic             valid_out,
  output logic             timeout_out,
  output logic             busy_out
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] TO         = WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE,
    WAIT_LOW
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   echo_s, echo_d;
  logic                   rise, fall, tick;
  logic [PW-1:0]          presc, presc_n;
  logic [WIDTH-1:0]       elapsed, elapsed_n;
  logic [WIDTH-1:0]       count, count_n, count_inc;
  logic [WIDTH-1:0]       width_n;
  logic                   valid_n, timeout_n;

  assign echo_s = sync_q[SYNC_STAGES-1];
  assign rise   = echo_s & ~echo_d;
  assign fall   = ~echo_s & echo_d;
  assign tick   = (presc == PRESC_LAST);

  // Synchronise the raw echo and keep a one-cycle delayed copy for edge detection
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      echo_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], echo_in};
      echo_d <= echo_s;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      presc       <= '0;
      elapsed     <= '0;
      count       <= '0;
      width_out   <= '0;
      valid_out   <= 1'b0;
      timeout_out <= 1'b0;
      busy_out    <= 1'b0;
    end else begin
      state       <= state_n;
      presc       <= presc_n;
      elapsed     <= elapsed_n;
      count       <= count_n;
      width_out   <= width_n;
      valid_out   <= valid_n;
      timeout_out <= timeout_n;
      busy_out    <= (state_n != IDLE);
    end
  end

  // Next-state, counter and output decisions
  always_comb begin
    state_n   = state;
    presc_n   = tick ? '0 : presc + PW'(1);
    elapsed_n = elapsed;
    count_n   = count;
    width_n   = width_out;
    valid_n   = 1'b0;
    timeout_n = 1'b0;
    count_inc = (tick && (count != TO)) ? count + WIDTH'(1) : count;

    case (state)
      IDLE: begin
        presc_n = '0;
        if (arm_in) begin
          state_n   = WAIT_RISE;
          elapsed_n = '0;
        end
      end
      WAIT_RISE: begin
        if (tick && (elapsed != TO)) elapsed_n = elapsed + WIDTH'(1);
        if (rise) begin
          state_n = MEASURE;
          count_n = '0;
        end else if (elapsed == TO) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
        end
      end
      MEASURE: begin
        count_n = count_inc;
        // The tick landing in the fall cycle is included; count_inc already
        // stops at TO, so a fall coinciding with saturation reports TIMEOUT.
        if (fall) begin
          state_n = IDLE;
          width_n = count_inc;
          valid_n = 1'b1;
        end else if (count == TO) begin
          state_n   = WAIT_LOW;
          timeout_n = 1'b1;
        end
      end
      WAIT_LOW: begin
        presc_n = '0;
        if (!echo_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Every state entry restarts the prescaler
    if (state_n != state) presc_n = '0;
  end

endmodule

// File: tb/tb_echo_timer.sv
// Self-checking bench for echo_timer (WIDTH=8, CLK_DIV=4, TIMEOUT=20, SYNC_STAGES=2).
// Expected strobes are queued when stimulus is driven; a monitor queues the
// strobes the DUT produces, and each test task pops and compares them.
module tb_echo_timer;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       arm_in = 1'b0;
  logic       echo_in = 1'b0;
  logic [7:0] width_out;
  logic       valid_out, timeout_out, busy_out;

  typedef struct {
    bit is_valid;
    int width;
  } exp_t;

  typedef struct {
    bit is_valid;
    int width;
    int cyc;
    bit busy;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_width = 0;
  bit   prev_strobe = 0;

  echo_timer #(
    .WIDTH      (8),
    .CLK_DIV    (4),
    .TIMEOUT    (20),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .arm_in     (arm_in),
    .echo_in    (echo_in),
    .width_out  (width_out),
    .valid_out  (valid_out),
    .timeout_out(timeout_out),
    .busy_out   (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Collect every strobe; strobes must be exclusive and never back to back
  always @(negedge clk_in) begin
    if (reset) begin
      prev_strobe = 0;
    end else begin
      if (valid_out || timeout_out) begin
        n_tests++;
        if ((valid_out && timeout_out) || prev_strobe) begin
          n_fail++;
          $display("FAIL strobe_excl: valid=%0b timeout=%0b prev=%0b, required single exclusive strobe",
                   valid_out, timeout_out, prev_strobe);
        end
        obs_q.push_back('{valid_out, int'(width_out), cyc, busy_out});
      end
      prev_strobe = valid_out || timeout_out;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_obs(input int budget, output bit got);
    for (int i = 0; i < budget && obs_q.size() == 0; i++) tick_n(1);
    got = (obs_q.size() > 0);
  endtask

  task automatic arm_pulse();
    arm_in = 1'b1;
    tick_n(1);
    arm_in = 1'b0;
  endtask

  task automatic test_reset();
    tick_n(3);
    n_tests++;
    if ({width_out, valid_out, timeout_out, busy_out} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got w=%0d v=%0b t=%0b b=%0b, required all 0",
               width_out, valid_out, timeout_out, busy_out);
    end
    reset = 1'b0;
    tick_n(3);
    n_tests++;
    if ({valid_out, timeout_out, busy_out} !== 3'b000 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got v=%0b t=%0b b=%0b events=%0d, required idle",
               valid_out, timeout_out, busy_out, obs_q.size());
    end
  endtask

  task automatic test_measure(input string name, input int high, input int want);
    exp_t e; obs_t o; bit got; int c;
    arm_pulse();
    tick_n(9);
    echo_in = 1'b1;
    exp_q.push_back('{1'b1, want});
    tick_n(high);
    echo_in = 1'b0;
    c = cyc;
    wait_obs(12, got);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_event: got no strobe, required valid", name);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    if (o.is_valid !== e.is_valid || o.width !== e.width) begin
      n_fail++;
      $display("FAIL %s_width: got valid=%0b width=%0d, required valid=%0b width=%0d",
               name, o.is_valid, o.width, e.is_valid, e.width);
    end
    n_tests++;
    if (o.cyc - c !== 3 || o.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles busy=%0b, required 3 cycles busy=0",
               name, o.cyc - c, o.busy);
    end
    last_width = want;
    tick_n(5);
  endtask

  task automatic test_no_echo();
    exp_t e; obs_t o; bit got; int a;
    arm_pulse();
    a = cyc;
    exp_q.push_back('{1'b0, last_width});
    wait_obs(120, got);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL no_echo_event: got no strobe, required timeout");
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    if (o.is_valid !== e.is_valid || o.width !== e.width) begin
      n_fail++;
      $display("FAIL no_echo_kind: got valid=%0b width=%0d, required valid=%0b width=%0d",
               o.is_valid, o.width, e.is_valid, e.width);
    end
    n_tests++;
    if (o.cyc - a < 76 || o.cyc - a > 86) begin
      n_fail++;
      $display("FAIL no_echo_time: got %0d cycles after arm, required about 80", o.cyc - a);
    end
    tick_n(1);
    n_tests++;
    if (busy_out !== 1'b0 || int'(width_out) !== last_width) begin
      n_fail++;
      $display("FAIL no_echo_after: got busy=%0b width=%0d, required busy=0 width=%0d",
               busy_out, width_out, last_width);
    end
    tick_n(3);
  endtask

  task automatic test_long_echo();
    exp_t e; obs_t o; int c; int d;
    arm_pulse();
    tick_n(4);
    echo_in = 1'b1;
    exp_q.push_back('{1'b0, last_width});
    tick_n(120);
    n_tests++;
    if (obs_q.size() != 1 || busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL long_events: got %0d strobes busy=%0b, required 1 strobe busy=1",
               obs_q.size(), busy_out);
    end
    echo_in = 1'b0;
    c = cyc;
    if (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o.is_valid !== e.is_valid || o.width !== e.width || o.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL long_kind: got valid=%0b width=%0d busy=%0b, required valid=0 width=%0d busy=1",
                 o.is_valid, o.width, o.busy, e.width);
      end
    end else begin
      void'(exp_q.pop_front());
    end
    d = 0;
    for (int i = 0; i < 8 && busy_out; i++) begin
      tick_n(1);
      d++;
    end
    n_tests++;
    if (d < 2 || d > 4 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL long_busy_drop: got %0d cycles busy=%0b, required about 3 and busy=0", d, busy_out);
    end
    tick_n(4);
    n_tests++;
    if (obs_q.size() != 0 || int'(width_out) !== last_width) begin
      n_fail++;
      $display("FAIL long_tail: got %0d strobes width=%0d, required 0 strobes width=%0d",
               obs_q.size(), width_out, last_width);
    end
  endtask

  task automatic test_early_echo();
    exp_t e; obs_t o; bit got;
    echo_in = 1'b1;
    tick_n(5);
    arm_pulse();
    tick_n(29);
    echo_in = 1'b0;
    tick_n(8);
    echo_in = 1'b1;
    exp_q.push_back('{1'b1, 4});
    tick_n(16);
    echo_in = 1'b0;
    wait_obs(12, got);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL early_event: got no strobe, required valid");
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    if (o.is_valid !== e.is_valid || o.width !== e.width) begin
      n_fail++;
      $display("FAIL early_width: got valid=%0b width=%0d, required valid=%0b width=%0d",
               o.is_valid, o.width, e.is_valid, e.width);
    end
    last_width = 4;
    tick_n(5);
  endtask

  task automatic test_reset_mid_measure();
    exp_t e; obs_t o; bit got;
    arm_pulse();
    tick_n(3);
    echo_in = 1'b1;
    tick_n(20);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({width_out, valid_out, timeout_out, busy_out} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset: got w=%0d v=%0b t=%0b b=%0b, required all 0",
               width_out, valid_out, timeout_out, busy_out);
    end
    echo_in = 1'b0;
    tick_n(2);
    #2;
    reset = 1'b0;
    last_width = 0;
    tick_n(2);
    arm_pulse();
    tick_n(4);
    echo_in = 1'b1;
    exp_q.push_back('{1'b1, 10});
    for (int i = 0; i < 40; i++) begin
      arm_in = (i % 8 == 2);
      tick_n(1);
    end
    arm_in  = 1'b0;
    echo_in = 1'b0;
    wait_obs(12, got);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL rearm_event: got no strobe, required valid");
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    if (o.is_valid !== e.is_valid || o.width !== e.width) begin
      n_fail++;
      $display("FAIL rearm_width: got valid=%0b width=%0d, required valid=%0b width=%0d",
               o.is_valid, o.width, e.is_valid, e.width);
    end
    last_width = 10;
    tick_n(10);
    n_tests++;
    if (obs_q.size() != 0 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_quiet: got %0d strobes busy=%0b, required none and idle",
               obs_q.size(), busy_out);
    end
  endtask

  initial begin
    test_reset();
    test_measure("basic40", 40, 10);
    test_measure("trunc43", 43, 10);
    test_measure("trunc44", 44, 11);
    test_no_echo();
    test_long_echo();
    test_early_echo();
    test_reset_mid_measure();
    n_tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d expected and %0d observed left, required 0 and 0",
               exp_q.size(), obs_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
